// File: rtl/bram_arb_pkg.sv
// Shared types for the two-client BRAM read arbiter: client ids, credit width
// and the issue-stage record carried from grant to data return.
package bram_arb_pkg;

   typedef logic [0:0] client_id_t;

   localparam int CREDIT_W     = 2;
   localparam int ISSUE_DATA_W = 32;

   typedef struct packed {
      logic                    valid;
      client_id_t              id;
      logic                    bypass;
      logic [ISSUE_DATA_W-1:0] data;
   } issue_t;

endpackage

// File: rtl/bram_arb_rsp_fifo.sv
// Two-entry response FIFO with a registered head word; count is the occupancy.
// Callers only pop when valid and only push when a credit was reserved.
module bram_arb_rsp_fifo
   import bram_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                push,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                pop,
   output logic                valid,
   output logic [DATA_W-1:0]   data_out,
   output logic [CREDIT_W-1:0] count
);

   localparam logic [CREDIT_W-1:0] EMPTY = CREDIT_W'(0);
   localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] FULL  = CREDIT_W'(2);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;

   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= EMPTY;
      end else begin
         count <= count + CREDIT_W'(push) - CREDIT_W'(pop);
      end
   end

   // Head is refilled from the tail on a full pop, or directly from the input
   // when the incoming word becomes the oldest entry.
   always_ff @(posedge CLK) begin
      if (pop && count == FULL) begin
         head <= tail;
      end else if (push && (count == EMPTY || (count == ONE && pop))) begin
         head <= data_in;
      end
      if (push && ((count == ONE && !pop) || (count == FULL && pop))) begin
         tail <= data_in;
      end
   end

   assign valid    = (count != EMPTY);
   assign data_out = head;

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of one registered-read BRAM port between two clients with
// credit-based response flow control, plus write pass-through with write-first bypass.
module bram_read_arbiter
   import bram_arb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int RSP_DEPTH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rd0_req_valid,
   input  logic [ADDR_W-1:0] rd0_req_addr,
   output logic              rd0_req_ready,
   output logic              rd0_rsp_valid,
   output logic [DATA_W-1:0] rd0_rsp_data,
   input  logic              rd0_rsp_ready,
   input  logic              rd1_req_valid,
   input  logic [ADDR_W-1:0] rd1_req_addr,
   output logic              rd1_req_ready,
   output logic              rd1_rsp_valid,
   output logic [DATA_W-1:0] rd1_rsp_data,
   input  logic              rd1_rsp_ready,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              bram_read_enable,
   output logic [ADDR_W-1:0] bram_read_addr,
   input  logic [DATA_W-1:0] bram_read_data,
   output logic              bram_write_enable,
   output logic [ADDR_W-1:0] bram_write_addr,
   output logic [DATA_W-1:0] bram_write_data
);

   if (RSP_DEPTH != 2 || DATA_W != ISSUE_DATA_W) begin : gUnsupported
      $error("bram_read_arbiter: RSP_DEPTH must be 2 and DATA_W must match ISSUE_DATA_W");
   end

   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(RSP_DEPTH);

   logic [1:0]          reqValid;
   logic [1:0]          rspReady;
   logic [1:0]          fifoValid;
   logic [1:0]          rspValid;
   logic [1:0]          pop;
   logic [1:0]          push;
   logic [1:0]          elig;
   logic [1:0]          grant;
   logic [ADDR_W-1:0]   reqAddr [2];
   logic [DATA_W-1:0]   rspData [2];
   logic [CREDIT_W-1:0] credits [2];
   logic [CREDIT_W-1:0] creditsAfterPop [2];
   logic [CREDIT_W-1:0] fifoCount [2];
   client_id_t          winner;
   client_id_t          lastGrant;
   logic                anyGrant;
   issue_t              issueNext;
   issue_t              issue_p0;
   logic [DATA_W-1:0]   retData_p1;

   assign reqValid   = {rd1_req_valid, rd0_req_valid};
   assign rspReady   = {rd1_rsp_ready, rd0_rsp_ready};
   assign reqAddr[0] = rd0_req_addr;
   assign reqAddr[1] = rd1_req_addr;

   // A response popped this cycle frees its credit for a same-cycle grant.
   always_comb begin
      rspValid        = '0;
      pop             = '0;
      elig            = '0;
      creditsAfterPop = '{default: '0};
      for (int c = 0; c < 2; c++) begin
         rspValid[c]        = fifoValid[c] & ~RST;
         pop[c]             = rspValid[c] & rspReady[c];
         creditsAfterPop[c] = credits[c] - CREDIT_W'(pop[c]);
         elig[c]            = reqValid[c] & (creditsAfterPop[c] < CREDIT_MAX) & ~RST;
      end
   end

   always_comb begin
      winner = 1'b0;
      if (elig[0] && elig[1]) begin
         winner = ~lastGrant;
      end else if (elig[1]) begin
         winner = 1'b1;
      end
      anyGrant = |elig;
      grant    = {anyGrant & winner, anyGrant & ~winner};
   end

   assign rd0_req_ready     = grant[0];
   assign rd1_req_ready     = grant[1];
   assign bram_read_enable  = anyGrant;
   assign bram_read_addr    = reqAddr[winner];
   assign bram_write_enable = wr_valid & ~RST;
   assign bram_write_addr   = wr_addr;
   assign bram_write_data   = wr_data;

   always_ff @(posedge CLK) begin
      if (RST) begin
         lastGrant <= 1'b1;
         credits   <= '{default: '0};
      end else begin
         if (anyGrant) begin
            lastGrant <= winner;
         end
         for (int c = 0; c < 2; c++) begin
            credits[c] <= credits[c] + CREDIT_W'(grant[c]) - CREDIT_W'(pop[c]);
            creditOverflow: assert (!(grant[c] && !pop[c] && credits[c] == CREDIT_MAX));
            creditCoversFifo: assert (fifoCount[c] <= credits[c]);
         end
      end
   end

   // Issue stage boundary: the same-cycle write is captured so later writes cannot leak in.
   always_comb begin
      issueNext        = '0;
      issueNext.valid  = anyGrant;
      issueNext.id     = winner;
      issueNext.bypass = wr_valid & (wr_addr == bram_read_addr);
      issueNext.data   = wr_data;
   end

   always_ff @(posedge CLK) begin
      issue_p0 <= issueNext;
      if (RST) begin
         issue_p0.valid <= 1'b0;
      end
   end

   // Return stage boundary: RAM data arrives, bypass overrides it, owner FIFO takes it.
   assign retData_p1 = issue_p0.bypass ? issue_p0.data : bram_read_data;
   assign push       = {issue_p0.valid & (issue_p0.id == 1'b1),
                        issue_p0.valid & (issue_p0.id == 1'b0)};

   for (genvar c = 0; c < 2; c++) begin : gClient
      bram_arb_rsp_fifo #(
         .DATA_W(DATA_W)
      ) uRspFifo (
         .CLK     (CLK),
         .RST     (RST),
         .push    (push[c]),
         .data_in (retData_p1),
         .pop     (pop[c]),
         .valid   (fifoValid[c]),
         .data_out(rspData[c]),
         .count   (fifoCount[c])
      );
   end

   assign rd0_rsp_valid = rspValid[0];
   assign rd1_rsp_valid = rspValid[1];
   assign rd0_rsp_data  = rspData[0];
   assign rd1_rsp_data  = rspData[1];

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Randomized and directed bench for bram_read_arbiter against a queue-based
// per-client outstanding-request model and a behavioural registered-read RAM.
module tb_bram_read_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;

   logic              CLK = 1'b0;
   logic              RST;
   logic              rd0_req_valid, rd0_req_ready, rd0_rsp_valid, rd0_rsp_ready;
   logic              rd1_req_valid, rd1_req_ready, rd1_rsp_valid, rd1_rsp_ready;
   logic [ADDR_W-1:0] rd0_req_addr, rd1_req_addr;
   logic [DATA_W-1:0] rd0_rsp_data, rd1_rsp_data;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              bram_read_enable, bram_write_enable;
   logic [ADDR_W-1:0] bram_read_addr, bram_write_addr;
   logic [DATA_W-1:0] bram_read_data, bram_write_data;

   bram_read_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RSP_DEPTH(2)) dut (
      .CLK(CLK), .RST(RST),
      .rd0_req_valid(rd0_req_valid), .rd0_req_addr(rd0_req_addr), .rd0_req_ready(rd0_req_ready),
      .rd0_rsp_valid(rd0_rsp_valid), .rd0_rsp_data(rd0_rsp_data), .rd0_rsp_ready(rd0_rsp_ready),
      .rd1_req_valid(rd1_req_valid), .rd1_req_addr(rd1_req_addr), .rd1_req_ready(rd1_req_ready),
      .rd1_rsp_valid(rd1_rsp_valid), .rd1_rsp_data(rd1_rsp_data), .rd1_rsp_ready(rd1_rsp_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .bram_read_enable(bram_read_enable), .bram_read_addr(bram_read_addr),
      .bram_read_data(bram_read_data),
      .bram_write_enable(bram_write_enable), .bram_write_addr(bram_write_addr),
      .bram_write_data(bram_write_data)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DATA_W-1:0] initVal(int a);
      if (a == 5) return 32'h0000_A5A5;
      if (a == 7) return 32'h0;
      return 32'h1357_0000 ^ (a * 32'h0001_0101);
   endfunction

   // RAM: read-before-write on a same-address collision, registered read data.
   logic [DATA_W-1:0] ramMem [512];
   bit                ramWr  [512];
   logic [DATA_W-1:0] ramRdData;
   assign bram_read_data = ramRdData;

   always @(posedge CLK) begin
      if (bram_write_enable) begin
         ramMem[bram_write_addr] <= bram_write_data;
         ramWr[bram_write_addr]  <= 1'b1;
      end
      if (bram_read_enable)
         ramRdData <= ramWr[bram_read_addr] ? ramMem[bram_read_addr] : initVal(int'(bram_read_addr));
   end

   typedef struct {
      logic [DATA_W-1:0] data;
      int                cyc;
   } rsp_t;

   rsp_t              q0[$];
   rsp_t              q1[$];
   logic [DATA_W-1:0] refMem [512];
   int                lastG;
   int                cyc;
   int                nChecks;
   int                nPass;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Clients hold the oldest outstanding request; a response is due two cycles after acceptance.
   task automatic modelCheck();
      logic              expV0, expV1, pop0, pop1, e0, e1, g0, g1;
      logic [ADDR_W-1:0] a;
      rsp_t              r;
      if (RST) begin
         checkVal("rst_rd0_ready", rd0_req_ready, 0);
         checkVal("rst_rd1_ready", rd1_req_ready, 0);
         checkVal("rst_rd0_valid", rd0_rsp_valid, 0);
         checkVal("rst_rd1_valid", rd1_rsp_valid, 0);
         checkVal("rst_rd_en", bram_read_enable, 0);
         checkVal("rst_wr_en", bram_write_enable, 0);
         q0.delete();
         q1.delete();
         lastG = 1;
         return;
      end
      expV0 = 1'b0;
      expV1 = 1'b0;
      if (q0.size() > 0) expV0 = (q0[0].cyc <= cyc - 2);
      if (q1.size() > 0) expV1 = (q1[0].cyc <= cyc - 2);
      checkVal("rd0_rsp_valid", rd0_rsp_valid, expV0);
      checkVal("rd1_rsp_valid", rd1_rsp_valid, expV1);
      if (expV0) checkVal("rd0_rsp_data", rd0_rsp_data, q0[0].data);
      if (expV1) checkVal("rd1_rsp_data", rd1_rsp_data, q1[0].data);
      pop0 = expV0 & rd0_rsp_ready;
      pop1 = expV1 & rd1_rsp_ready;
      e0 = rd0_req_valid && (int'(q0.size()) - int'(pop0) < 2);
      e1 = rd1_req_valid && (int'(q1.size()) - int'(pop1) < 2);
      g0 = e0 && (!e1 || lastG == 1);
      g1 = e1 && (!e0 || lastG == 0);
      checkVal("rd0_req_ready", rd0_req_ready, g0);
      checkVal("rd1_req_ready", rd1_req_ready, g1);
      checkVal("bram_rd_en", bram_read_enable, g0 | g1);
      a = g0 ? rd0_req_addr : rd1_req_addr;
      if (g0 | g1) checkVal("bram_rd_addr", bram_read_addr, a);
      checkVal("bram_wr_en", bram_write_enable, wr_valid);
      if (wr_valid) begin
         checkVal("bram_wr_addr", bram_write_addr, wr_addr);
         checkVal("bram_wr_data", bram_write_data, wr_data);
      end
      r.data = (wr_valid && wr_addr == a) ? wr_data : refMem[a];
      r.cyc  = cyc;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (g0) begin q0.push_back(r); lastG = 0; end
      if (g1) begin q1.push_back(r); lastG = 1; end
      if (wr_valid) refMem[wr_addr] = wr_data;
   endtask

   task automatic cycle();
      @(negedge CLK);
      modelCheck();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic setIdle();
      rd0_req_valid = 0; rd1_req_valid = 0; wr_valid = 0;
      rd0_rsp_ready = 1; rd1_rsp_ready = 1;
   endtask

   int          nAcc0, nAcc1;
   logic [8:0]  addr0, addr1;
   logic        acc0, acc1;

   initial begin
      nChecks = 0; nPass = 0; cyc = 0; lastG = 1;
      for (int i = 0; i < 512; i++) refMem[i] = initVal(i);
      RST = 1; setIdle();
      rd0_req_addr = '0; rd1_req_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) cycle();

      // Single read of addr 5 right after reset.
      RST = 0; rd0_req_valid = 1; rd0_req_addr = 9'd5;
      #2 checkVal("t1_accept", rd0_req_ready, 1);
      cycle();
      rd0_req_valid = 0;
      cycle();
      #2;
      checkVal("t1_rsp_valid", rd0_rsp_valid, 1);
      checkVal("t1_rsp_data", rd0_rsp_data, 32'h0000_A5A5);
      checkVal("t1_rd1_idle", rd1_rsp_valid, 0);
      repeat (3) cycle();

      // Both clients saturating.
      addr0 = 9'd16; addr1 = 9'd100;
      for (int i = 0; i < 24; i++) begin
         rd0_req_valid = 1; rd0_req_addr = addr0;
         rd1_req_valid = 1; rd1_req_addr = addr1;
         #2; acc0 = rd0_req_ready; acc1 = rd1_req_ready;
         cycle();
         if (acc0) addr0++;
         if (acc1) addr1++;
      end
      setIdle();
      repeat (4) cycle();

      // rd0 stops consuming: two accepts only, rd1 keeps going.
      nAcc0 = 0; nAcc1 = 0; rd0_rsp_ready = 0;
      for (int i = 0; i < 12; i++) begin
         rd0_req_valid = 1; rd0_req_addr = addr0;
         rd1_req_valid = 1; rd1_req_addr = addr1;
         #2; acc0 = rd0_req_ready; acc1 = rd1_req_ready;
         cycle();
         if (acc0) begin addr0++; nAcc0++; end
         if (acc1) begin addr1++; nAcc1++; end
      end
      checkVal("stall_rd0_accepts", nAcc0, 2);
      checkVal("stall_rd1_served", nAcc1 >= 10, 1);
      setIdle();
      repeat (6) cycle();

      // Same-cycle write to the address being read, then a later write.
      rd1_req_valid = 1; rd1_req_addr = 9'd7;
      wr_valid = 1; wr_addr = 9'd7; wr_data = 32'h0000_1234;
      #2 checkVal("byp_accept", rd1_req_ready, 1);
      cycle();
      rd1_req_valid = 0; wr_data = 32'h0000_5678;
      cycle();
      wr_valid = 0;
      #2;
      checkVal("byp_valid", rd1_rsp_valid, 1);
      checkVal("byp_data", rd1_rsp_data, 32'h0000_1234);
      repeat (3) cycle();

      // Reset right after an accept, then a tie.
      rd0_req_valid = 1; rd0_req_addr = 9'd3;
      #2 checkVal("rst_pre_accept", rd0_req_ready, 1);
      cycle();
      RST = 1; rd0_req_valid = 0;
      repeat (2) cycle();
      RST = 0;
      rd0_req_valid = 1; rd0_req_addr = 9'd4;
      rd1_req_valid = 1; rd1_req_addr = 9'd9;
      #2;
      checkVal("tie_rd0_wins", rd0_req_ready, 1);
      checkVal("tie_rd1_waits", rd1_req_ready, 0);
      cycle();
      setIdle();
      #2 checkVal("rst_no_stale_rsp", rd0_rsp_valid, 0);
      repeat (4) cycle();

      // Randomized traffic with small address space to force collisions.
      for (int i = 0; i < 3000; i++) begin
         RST           = ($urandom_range(0, 149) == 0);
         rd0_req_valid = ($urandom_range(0, 3) != 0);
         rd0_req_addr  = 9'($urandom_range(0, 15));
         rd0_rsp_ready = ($urandom_range(0, 2) != 0);
         rd1_req_valid = ($urandom_range(0, 3) != 0);
         rd1_req_addr  = 9'($urandom_range(0, 15));
         rd1_rsp_ready = ($urandom_range(0, 2) != 0);
         wr_valid      = ($urandom_range(0, 1) != 0);
         wr_addr       = 9'($urandom_range(0, 15));
         wr_data       = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/bram_read_arbiter.md
# bram_read_arbiter

Shares the single read port of a one-read/one-write block RAM (registered read data, 1-cycle latency) between two read clients, with round-robin arbitration and credit-based response flow control. Also passes one write stream to the RAM write port and gives write-first semantics for a same-address read and write in the same cycle. Sits between the RAM wrapper and two independent consumers, for example a lookup engine and a debug scan.

## Interface
- DATA_W, 32: RAM word width
- ADDR_W, 9: RAM address width
- RSP_DEPTH, 2: per-client response buffer entries (fixed at 2; other values unsupported)

Ports (client index c ∈ {0,1}):
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- rdc_req_valid  in  1  client c read request
- rdc_req_addr  in  ADDR_W  request address
- rdc_req_ready  out  1  request accepted when valid&ready
- rdc_rsp_valid  out  1  response available
- rdc_rsp_data  out  DATA_W  response word
- rdc_rsp_ready  in  1  client consumes response
- wr_valid  in  1  write request; always accepted
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- bram_read_enable  out  1  RAM read strobe
- bram_read_addr  out  ADDR_W  RAM read address
- bram_read_data  in  DATA_W  RAM read data, valid 1 cycle after the strobe
- bram_write_enable  out  1  = wr_valid & !RST
- bram_write_addr  out  ADDR_W  = wr_addr
- bram_write_data  out  DATA_W  = wr_data

## Operation
- Credit counter per client: credits_c = response buffer occupancy + reads in flight, range 0..2.
- Client c is eligible when rdc_req_valid is high and (credits_c − pop_c) < 2, where pop_c = rdc_rsp_valid & rdc_rsp_ready.
- Arbitration:
  - One client eligible: that client is granted.
  - Both eligible: grant goes to the client that is not last_grant. last_grant updates on every grant.
- rdc_req_ready = eligible_c & granted_c.
- Grant cycle:
  - bram_read_enable = 1 and bram_read_addr = the winner's address.
  - Issue-stage register captures {valid, client id, bypass flag, bypass data}.
- Bypass: bypass flag = wr_valid & (wr_addr == granted addr); bypass data = wr_data. A write in any later cycle does not affect this read.
- Return stage (cycle after grant): data = bypass ? bypass data : bram_read_data. It is pushed into the owning client's 2-entry FIFO at the end of that cycle.
- FIFO head drives rdc_rsp_data and rdc_rsp_valid; data is held stable while valid & !ready.
- Credits: +1 on grant, −1 on pop; both in the same cycle leave the count unchanged. Overflow is impossible by construction. An assertion flags an overflow.

## Timing
- Accept in cycle T → bram_read_enable high in T → rdc_rsp_valid high in T+2 at the earliest.
- One client alone with rdc_rsp_ready held high: one accept per cycle, sustained.
- Both clients saturating: strict alternation, one read per cycle in total.
- Response order per client equals its request order. The two clients are not ordered relative to each other.
- While RST is high:
  - All outputs are 0: req_ready, rsp_valid, bram enables.
  - Issue stage and FIFOs are cleared; credits = 0; last_grant = 1, so client 0 wins the first tie.
- Reset mid-operation: in-flight reads are discarded and their responses are never delivered. The first accept is possible in the first cycle with RST low.
- Write with no read in the same cycle: passed through with no effect on arbitration.

## Structure
- Package bram_arb_pkg holds:
  - client_id_t (1 bit)
  - CREDIT_W = 2
  - the issue-stage struct {valid, id, bypass, data}
- Sub-module bram_arb_rsp_fifo: 2-entry FIFO with registered head. Interface: push, data_in, pop, valid, data_out, count. It is instantiated once per client.
- The top level holds the arbiter, credit counters, issue register and write pass-through.

## Test plan
- Reset, then rd0 requests addr 5 (RAM[5]=0xA5A5): accepted cycle 1; rd0_rsp_valid in cycle 3 with 0xA5A5; rd1 sees nothing.
- Both clients request continuously, rsp_ready high: grants go 0,1,0,1…; each client receives exactly its own addresses in order.
- rd0 with rsp_ready low: exactly 2 accepts, then rd0_req_ready stays low. rd1 is still served every cycle.
- wr_valid to addr 7 (data 0x1234) in the same cycle rd1 reads addr 7 (old value 0x0): response is 0x1234. A write to addr 7 one cycle after the read still returns 0x1234 from the bypass; the new write does not affect the response.
- RST asserted one cycle after an accept: no response is ever delivered for that request. After release, credits are 0 and rd0 wins a simultaneous tie.
